// File: rtl/pkg_display.sv
// pkg_display: shared types and segment patterns for the display mux.
// Digit index, active-high seg_t {g..a}, SEG_0..SEG_9, SEG_DASH, SEG_OFF.
package pkg_display;

  typedef logic [1:0] idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t SEG_OFF  = 7'h00;

  function automatic logic [3:0] an_onehot(idx_t i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/module_bcd_7seg.sv
// module_bcd_7seg: combinational BCD to active-high segments, dash for >9.
// Ports: bcd_i (4-bit digit) -> seg_o ({g..a}, 1 = lit).
module module_bcd_7seg
  import pkg_display::*;
(
  input  logic [3:0] bcd_i,
  output seg_t       seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/module_display_mux.sv
// module_display_mux: 4-digit multiplexed 7-seg driver, digits latched per frame.
// Ports: clk, rst (sync, active-high), unidades/decenas/centenas/milesimas_input
// -> segmentos_output {g..a}, anodos_output (bit0=units). Option: LEADING_ZERO_BLANK_EN.
module module_display_mux
  import pkg_display::*;
#(
  parameter int REFRESH_DIV    = 27000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] unidades_input,
  input  logic [3:0] decenas_input,
  input  logic [3:0] centenas_input,
  input  logic [3:0] milesimas_input,
  output logic [6:0] segmentos_output,
  output logic [3:0] anodos_output
);

  if (REFRESH_DIV < 1) begin : g_bad_div
    $error("REFRESH_DIV must be >= 1");
  end

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [3:0] AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam seg_t       SEG_IDL = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [CW-1:0]   cnt_q, cnt_d;
  idx_t            idx_q, idx_d;
  logic [3:0][3:0] sh_q, sh_d;
  logic [3:0]      an_q, an_d;
  seg_t            seg_q, seg_d;

  logic tick;
  logic blank;
  seg_t seg_raw;

  assign tick = (cnt_q == CNT_MAX);

  module_bcd_7seg u_dec (
    .bcd_i (sh_q[idx_q]),
    .seg_o (seg_raw)
  );

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A slot is blank only if it and every more significant digit are 0.
    case (idx_q)
      2'd3:    blank = (sh_q[3] == 4'd0);
      2'd2:    blank = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0);
      2'd1:    blank = (sh_q[3] == 4'd0) && (sh_q[2] == 4'd0)
                    && (sh_q[1] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    sh_d  = sh_q;
    // Latch the next frame only as the thousands slot ends: no tearing.
    if (tick && idx_q == 2'd3) begin
      sh_d = {milesimas_input, centenas_input,
              decenas_input, unidades_input};
    end
    an_d  = blank ? 4'h0 : an_onehot(idx_q);
    seg_d = blank ? SEG_OFF : seg_raw;
    if (AN_ACTIVE_LOW)  an_d  = ~an_d;
    if (SEG_ACTIVE_LOW) seg_d = ~seg_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      sh_q  <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_IDL;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q  <= sh_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign anodos_output    = an_q;
  assign segmentos_output = seg_q;

endmodule

// File: tb/tb_module_display_mux.sv
// tb_module_display_mux: randomized scoreboard bench for module_display_mux.
// Two instances: REFRESH_DIV=4 (active-low), REFRESH_DIV=1 (active-high anodes).
module tb_module_display_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] uni = 4'd0, dec = 4'd0, cen = 4'd0, mil = 4'd0;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  module_display_mux #(
    .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .unidades_input(uni), .decenas_input(dec),
    .centenas_input(cen), .milesimas_input(mil),
    .segmentos_output(seg_a), .anodos_output(an_a)
  );

  module_display_mux #(
    .REFRESH_DIV(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .unidades_input(uni), .decenas_input(dec),
    .centenas_input(cen), .milesimas_input(mil),
    .segmentos_output(seg_b), .anodos_output(an_b)
  );

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic exp_t off_out(bit segl, bit anl);
    exp_t e;
    e.an  = anl  ? 4'hF  : 4'h0;
    e.seg = segl ? 7'h7F : 7'h00;
    return e;
  endfunction

  // n = clean edges since reset release; f = digits shown this frame.
  function automatic exp_t model_out(int n, int rd, bit segl, bit anl,
                                     logic [3:0][3:0] f);
    exp_t e;
    int s;
    bit blank;
    s = (n / rd) % 4;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (s > 0) begin
      blank = 1'b1;
      for (int j = s; j < 4; j++)
        if (f[j] != 4'd0) blank = 1'b0;
    end
`endif
    e.an  = blank ? 4'h0 : 4'(1 << s);
    e.seg = blank ? 7'h00 : PAT[f[s]];
    if (anl)  e.an  = ~e.an;
    if (segl) e.seg = ~e.seg;
    return e;
  endfunction

  // Reference model: frame digits sampled once every 4*rd clean edges.
  initial begin
    int na, nb;
    logic [3:0][3:0] fa, fb, din;
    na = 0; nb = 0; fa = '0; fb = '0;
    forever begin
      @(posedge clk);
      din = {mil, cen, dec, uni};
      if (rst) begin
        qa.push_back(off_out(1'b1, 1'b1));
        qb.push_back(off_out(1'b1, 1'b0));
        na = 0; nb = 0; fa = '0; fb = '0;
      end else begin
        qa.push_back(model_out(na, 4, 1'b1, 1'b1, fa));
        qb.push_back(model_out(nb, 1, 1'b1, 1'b0, fb));
        na++; nb++;
        if (na % 16 == 0) fa = din;
        if (nb % 4 == 0)  fb = din;
      end
    end
  end

  // Monitor: outputs are compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL dutA empty scoreboard at %0t", $time);
      end else begin
        e = qa.pop_front();
        if (an_a !== e.an || seg_a !== e.seg) begin
          errors++;
          $display("FAIL dutA t=%0t an=%b seg=%b expected an=%b seg=%b",
                   $time, an_a, seg_a, e.an, e.seg);
        end
      end
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL dutB empty scoreboard at %0t", $time);
      end else begin
        e = qb.pop_front();
        if (an_b !== e.an || seg_b !== e.seg) begin
          errors++;
          $display("FAIL dutB t=%0t an=%b seg=%b expected an=%b seg=%b",
                   $time, an_b, seg_b, e.an, e.seg);
        end
      end
    end
  end

  task automatic run(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(logic [15:0] v);
    {mil, cen, dec, uni} = v;
  endtask

  initial begin
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(3);
    set_digits(16'h1234);
    run(40);
    set_digits(16'h00C0);
    run(40);
    set_digits(16'h0007);
    run(40);
    set_digits(16'h0000);
    run(40);
    set_digits(16'h1234);
    run(40);
    for (int i = 0; i < 20 && an_a != 4'b1011; i++) @(negedge clk);
    checks++;
    if (an_a != 4'b1011) begin
      errors++;
      $display("FAIL slot2_wait an=%b expected an=1011", an_a);
    end
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) set_digits(16'($urandom));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      else rst = 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    run(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
